// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing
// and the parity helper used by both receiver and transmitter.
package uart_rx_frame_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // Expected parity bit for up to 8 data bits; unused upper bits are zero.
    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic       odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so an idle line is seen during and after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: mid-bit sampling, optional parity check,
// framing-error detect and break handling.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_flag;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            perr_flag  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        perr_flag <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        // Shift in from the top: first bit ends at the LSB.
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        perr_flag <= rx_s != calc_parity(8'(shreg),
                                                         PARITY_ODD != 0);
                        state     <= STOP;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        data_out   <= shreg;
                        parity_err <= perr_flag;
                        frame_err  <= ~rx_s;
                        data_valid <= 1'b1;
                        cnt        <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frame-level model plus
// directed checks on glitch, break, back-to-back and reset cases.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + CPB;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   nvalid = 0;
    int   vt_prev = 0;
    int   vt_last = 0;
    logic saw_busy = 1'b0;

    logic [7:0] ld = '0;
    logic       lp = 1'b0;
    logic       lf = 1'b0;
    exp_t       q[$];

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: expectation derived from the bits put on the line.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic stop, input int stop_len);
        exp_t e;
        e.d    = d;
        e.perr = p != (^d);
        e.ferr = ~stop;
        e.due  = cyc + LAT;
        q.push_back(e);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold(CPB);
        end
        rx = p;
        hold(CPB);
        rx = stop;
        hold(stop_len);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (busy) saw_busy = 1'b1;
        if (!rst) begin
            q.delete();
            ld = '0;
            lp = 1'b0;
            lf = 1'b0;
        end else if (data_valid) begin
            nvalid++;
            vt_prev = vt_last;
            vt_last = cyc;
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(data_valid), 0);
            end else begin
                e = q.pop_front();
                chk("data", 32'(data_out), 32'(e.d));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("frame_err", 32'(frame_err), 32'(e.ferr));
                if (cyc < e.due - 1 || cyc > e.due + 1)
                    chk("valid_time", 32'(cyc), 32'(e.due));
                else
                    checks++;
                ld = e.d;
                lp = e.perr;
                lf = e.ferr;
            end
        end else begin
            chk("hold_data", 32'(data_out), 32'(ld));
            chk("hold_perr", 32'(parity_err), 32'(lp));
            chk("hold_ferr", 32'(frame_err), 32'(lf));
            if (q.size() != 0 && cyc > q[0].due + 1) begin
                chk("valid_missing", 32'(data_valid), 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        hold(5);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_perr", 32'(parity_err), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        hold(10);

        send_frame(8'hA5, 1'b0, 1'b1, CPB);
        hold(5);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_perr", 32'(parity_err), 0);
        chk("a5_ferr", 32'(frame_err), 0);
        chk("a5_busy", 32'(busy), 0);
        chk("a5_count", 32'(nvalid), 1);

        send_frame(8'h83, 1'b0, 1'b1, CPB);
        hold(5);
        chk("83_data", 32'(data_out), 32'h83);
        chk("83_perr", 32'(parity_err), 1);
        chk("83_ferr", 32'(frame_err), 0);

        send_frame(8'h07, 1'b1, 1'b0, CPB + 40);
        chk("07_data", 32'(data_out), 32'h07);
        chk("07_ferr", 32'(frame_err), 1);
        chk("07_perr", 32'(parity_err), 0);
        chk("break_busy", 32'(busy), 1);
        chk("break_count", 32'(nvalid), 3);
        rx = 1'b1;
        hold(10);
        chk("break_exit_busy", 32'(busy), 0);

        saw_busy = 1'b0;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(20);
        chk("glitch_busy_seen", 32'(saw_busy), 1);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_count", 32'(nvalid), 3);

        send_frame(8'hF0, 1'b0, 1'b1, CPB);
        send_frame(8'hAA, 1'b0, 1'b1, CPB);
        hold(5);
        chk("b2b_count", 32'(nvalid), 5);
        chk("b2b_spacing", 32'(vt_last - vt_prev), 11 * CPB);
        chk("b2b_data", 32'(data_out), 32'hAA);

        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(CPB);
        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(CPB);
        rx = 1'b0;
        hold(CPB / 2);
        rst = 1'b0;
        #1;
        chk("abort_data", 32'(data_out), 0);
        chk("abort_valid", 32'(data_valid), 0);
        chk("abort_ferr", 32'(frame_err), 0);
        chk("abort_busy", 32'(busy), 0);
        rx = 1'b1;
        hold(3);
        rst = 1'b1;
        hold(20);
        chk("abort_count", 32'(nvalid), 5);

        send_frame(8'h3C, 1'b0, 1'b1, CPB);
        hold(5);
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_perr", 32'(parity_err), 0);
        chk("3c_ferr", 32'(frame_err), 0);
        chk("3c_count", 32'(nvalid), 6);
        hold(20);
        chk("pending", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial-to-parallel UART receiver.
- Single clock, mid-bit sampling with a cycle counter, optional parity, framing-error detect.
- Sits at the far end of a UART link, opposite the transmitter of the complete UART block.
- Recovers bytes from the rx line and presents each with a one-cycle valid pulse and error flags to the local consumer.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (even, >= 4).
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY_EN, 1, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  DATA_BITS  last received byte, held until the next frame completes.
- data_valid  output  1  one-cycle pulse, frame complete.
- parity_err  output  1  valid with data_valid; 1 = parity mismatch.
- frame_err  output  1  valid with data_valid; 1 = stop bit sampled 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, counters 0, synchronizer flops set to 1 (idle line).
- rx passes through a 2-flop synchronizer. rx_s is the synchronized value and is the only value the FSM uses.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - rx_s=0 -> START, cnt=0.
  - busy=0.
- START:
  - cnt increments each clk.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - rx_s=1 -> glitch, return to IDLE, no output.
  - rx_s=0 -> DATA, cnt=0, bit_idx=0.
- DATA:
  - At cnt==CLKS_PER_BIT-1, sample rx_s into shift register bit bit_idx (LSB first).
  - On that sample, cnt=0 and bit_idx++.
  - After bit DATA_BITS-1 is sampled: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - At cnt==CLKS_PER_BIT-1, capture the parity bit.
  - Computed parity = XOR(data) ^ PARITY_ODD.
  - Mismatch sets an internal flag.
  - Then go to STOP, cnt=0.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - On the next clk edge: data_out <= shift reg, parity_err <= flag, frame_err <= ~rx_s, data_valid <= 1 for exactly one cycle.
  - rx_s=1 -> IDLE.
  - rx_s=0 -> BREAK.
- BREAK: wait until rx_s=1, then IDLE. No data_valid is emitted while in BREAK.
- Output hold rules:
  - parity_err and frame_err hold their value until the next data_valid.
  - data_out is updated even when an error flag is set.
- Latency (no parity): the falling edge on rx becomes rx_s 2 clks later. data_valid rises (2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1) clks after the rx edge, ±1 for synchronizer phase. PARITY_EN adds CLKS_PER_BIT.
- Back-to-back frames: IDLE accepts a new start edge on the cycle after STOP. A start bit that immediately follows the stop bit is received correctly.
- Reset asserted mid-frame aborts the frame: no data_valid, outputs cleared.
- A falling edge during BREAK is not treated as a start bit.

Decomposition:
- Shared UART include/package holds:
  - state encodings (3-bit localparams IDLE..BREAK);
  - default CLKS_PER_BIT;
  - the parity-compute function, shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer with asynchronous active-low reset to 1.
- All other logic stays in one FSM module.

Test Plan:
- Bit timing: CLKS_PER_BIT=16, even parity. Drive 0xA5 = start, bits LSB-first 1,0,1,0,0,1,0,1, parity 0, stop 1 -> data_valid single pulse, data_out=0xA5, parity_err=0, frame_err=0, busy returns to 0.
- Parity error: drive 0x83 with parity bit 0 (correct is 1) -> data_out=0x83, parity_err=1, frame_err=0.
- Framing error and break: drive 0x07 with stop=0, then hold rx low 40 clks -> data_out=0x07, frame_err=1. No second data_valid until rx returns high and a new frame is sent.
- Glitch rejection: rx low for 4 clks then high -> busy pulses, no data_valid, FSM back in IDLE.
- Back-to-back frames: 0xF0 then 0xAA with no idle gap -> two data_valid pulses exactly 11*16 clks apart, values 0xF0 then 0xAA.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x55 -> all outputs 0 immediately. After release, a clean 0x3C frame is received correctly.
